spi_master_ctrl: RTL and testbench

SPI master sequencer for the SmolBoi register slave. It accepts one register command at a time from an on-chip host over a start/busy/done handshake and generates CS, SCLK and MOSI. It samples MISO and returns read data. Each frame is 16 SCLK periods: RW bit, 7-bit address MSB first, then an 8-bit data phase MSB first. RW=0 is a write; RW=1 is a read.

---
 rtl/spi_master_ctrl_if.sv | 22 ++
 rtl/spi_master_ctrl.sv | 126 ++++++++++++
 tb/tb_spi_master_ctrl.sv | 291 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/spi_master_ctrl_if.sv
// Host-side command handshake for the SPI master sequencer.
interface spi_master_ctrl_if;
    logic       start;
    logic       rw;
    logic [6:0] addr;
    logic [7:0] wdata;
    logic       busy;
    logic       done;
    logic [7:0] rdata;

    // Host that issues commands
    modport master (
        output start, rw, addr, wdata,
        input  busy, done, rdata
    );

    // Sequencer that executes commands
    modport slave (
        input  start, rw, addr, wdata,
        output busy, done, rdata
    );
endinterface

// File: rtl/spi_master_ctrl.sv
// SPI master sequencer for the SmolBoi register slave.
// Frame: RW, 7-bit address, 8-bit data, all MSB first, SPI mode 0.
// One command at a time over a start/busy/done handshake.
module spi_master_ctrl #(
    parameter int unsigned CLK_DIV = 5
) (
    input  logic              CLK,
    input  logic              RESET,
    spi_master_ctrl_if.slave  host,
    output logic              CS,
    output logic              SCLK,
    output logic              MOSI,
    input  logic              MISO
);

    localparam int unsigned CW = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;

    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] SETUP = 3'd1;
    localparam logic [2:0] SHIFT = 3'd2;
    localparam logic [2:0] HOLD  = 3'd3;
    localparam logic [2:0] GAP   = 3'd4;

    logic [2:0]    state;
    logic [CW-1:0] div_cnt;
    logic          tick;
    logic [3:0]    bit_cnt;
    // Bits still to be sent after the RW bit; bit 15 of the frame goes
    // straight to MOSI on acceptance, so only 15 bits need holding here.
    logic [14:0]   rest;
    logic [7:0]    rreg;
    logic          rw_q;

    // Half-period tick at the last count of the divider
    always_comb begin
        tick = (div_cnt == CW'(CLK_DIV - 1));
    end

    // Divider counter: held at zero in IDLE, restarts on every tick so each
    // state entry begins a fresh half-period
    always_ff @(posedge CLK) begin
        if (RESET || state == IDLE || tick) begin
            div_cnt <= '0;
        end else begin
            div_cnt <= div_cnt + CW'(1);
        end
    end

    // Frame sequencer and all registered outputs
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state      <= IDLE;
            bit_cnt    <= '0;
            rest       <= '0;
            rreg       <= '0;
            rw_q       <= 1'b0;
            CS         <= 1'b1;
            SCLK       <= 1'b0;
            MOSI       <= 1'b0;
            host.busy  <= 1'b0;
            host.done  <= 1'b0;
            host.rdata <= '0;
        end else begin
            host.done <= 1'b0;
            case (state)
                IDLE: begin
                    if (host.start) begin
                        rw_q      <= host.rw;
                        rest      <= {host.addr, host.rw ? 8'h00 : host.wdata};
                        MOSI      <= host.rw;
                        rreg      <= '0;
                        bit_cnt   <= '0;
                        CS        <= 1'b0;
                        host.busy <= 1'b1;
                        state     <= SETUP;
                    end
                end
                SETUP: begin
                    if (tick) begin
                        state <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (tick) begin
                        if (!SCLK) begin
                            SCLK <= 1'b1;
                            if (rw_q && bit_cnt >= 4'd8) begin
                                rreg <= {rreg[6:0], MISO};
                            end
                        end else begin
                            SCLK <= 1'b0;
                            if (bit_cnt != 4'd15) begin
                                bit_cnt <= bit_cnt + 4'd1;
                                MOSI    <= rest[14];
                                rest    <= {rest[13:0], 1'b0};
                            end else begin
                                MOSI  <= 1'b0;
                                state <= HOLD;
                            end
                        end
                    end
                end
                HOLD: begin
                    if (tick) begin
                        CS    <= 1'b1;
                        state <= GAP;
                    end
                end
                GAP: begin
                    if (tick) begin
                        host.done <= 1'b1;
                        host.busy <= 1'b0;
                        if (rw_q) begin
                            host.rdata <= rreg;
                        end
                        state <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_spi_master_ctrl.sv
// Self-checking bench for spi_master_ctrl: a CLK_DIV=5 and a CLK_DIV=2
// instance share the clock and reset; a select muxes which one is exercised.
module tb_spi_master_ctrl;

    typedef struct {
        int unsigned div;
        logic        rw;
        logic [6:0]  addr;
        logic [7:0]  wdata;
        logic [7:0]  sbyte;
        logic [15:0] exp_frame;
        int unsigned exp_lat;
        logic [7:0]  exp_rdata;
    } vec_t;

    logic CLK = 1'b0;
    logic RESET = 1'b0;
    always #5 CLK = ~CLK;

    logic       sel = 1'b0;
    logic       start_v = 1'b0;
    logic       rw_v = 1'b0;
    logic [6:0] addr_v = '0;
    logic [7:0] wdata_v = '0;
    logic       miso_v = 1'b0;
    logic [7:0] slave_byte = '0;

    spi_master_ctrl_if h5 ();
    spi_master_ctrl_if h2 ();
    logic cs5, sclk5, mosi5, cs2, sclk2, mosi2;

    assign h5.start = start_v & ~sel;
    assign h5.rw    = rw_v;
    assign h5.addr  = addr_v;
    assign h5.wdata = wdata_v;
    assign h2.start = start_v & sel;
    assign h2.rw    = rw_v;
    assign h2.addr  = addr_v;
    assign h2.wdata = wdata_v;

    spi_master_ctrl #(.CLK_DIV(5)) dut5 (
        .CLK(CLK), .RESET(RESET), .host(h5),
        .CS(cs5), .SCLK(sclk5), .MOSI(mosi5), .MISO(miso_v)
    );
    spi_master_ctrl #(.CLK_DIV(2)) dut2 (
        .CLK(CLK), .RESET(RESET), .host(h2),
        .CS(cs2), .SCLK(sclk2), .MOSI(mosi2), .MISO(miso_v)
    );

    logic       cs_s, sclk_s, mosi_s, busy_s, done_s;
    logic [7:0] rdata_s;
    assign cs_s    = sel ? cs2 : cs5;
    assign sclk_s  = sel ? sclk2 : sclk5;
    assign mosi_s  = sel ? mosi2 : mosi5;
    assign busy_s  = sel ? h2.busy : h5.busy;
    assign done_s  = sel ? h2.done : h5.done;
    assign rdata_s = sel ? h2.rdata : h5.rdata;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference frame from the command fields by plain arithmetic
    function automatic int ref_frame(input logic rw, input logic [6:0] a, input logic [7:0] d);
        return int'(rw) * 32768 + int'(a) * 256 + (rw ? 0 : int'(d));
    endfunction

    // Cycle count and bus monitor / slave model, sampled on falling CLK
    int cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    int          rise_cnt = 0;
    int          stray = 0;
    int          busy_cnt = 0;
    logic [15:0] cur = '0;
    logic        cs_prev = 1'b1;
    logic        sclk_prev = 1'b0;
    int          fall_q[$];
    int          rise_q[$];
    int          done_q[$];
    int          busy_q[$];
    int          nrise_q[$];
    logic [15:0] frame_q[$];

    always @(negedge CLK) begin
        if (cs_prev === 1'b1 && cs_s === 1'b0) begin
            fall_q.push_back(cyc);
            rise_cnt = 0;
            cur = '0;
            busy_cnt = 0;
        end
        if (busy_s === 1'b1) busy_cnt++;
        if (sclk_s === 1'b1 && sclk_prev === 1'b0) begin
            if (cs_s === 1'b0) begin
                cur = {cur[14:0], mosi_s};
                rise_cnt++;
            end else begin
                stray++;
            end
        end
        if (sclk_s === 1'b0 && sclk_prev === 1'b1) begin
            miso_v = (rise_cnt >= 8 && rise_cnt <= 15) ? slave_byte[15 - rise_cnt] : 1'b0;
        end
        if (cs_s === 1'b1 && cs_prev === 1'b0) begin
            rise_q.push_back(cyc);
            frame_q.push_back(cur);
            nrise_q.push_back(rise_cnt);
        end
        if (done_s === 1'b1) begin
            done_q.push_back(cyc);
            busy_q.push_back(busy_cnt);
        end
        cs_prev = cs_s;
        sclk_prev = sclk_s;
    end

    task automatic clear_mon();
        fall_q.delete(); rise_q.delete(); done_q.delete();
        busy_q.delete(); nrise_q.delete(); frame_q.delete();
    endtask

    // One complete command; inputs are scrambled right after acceptance
    task automatic do_frame(input vec_t v);
        int nf;
        int nd;
        nf = fall_q.size();
        nd = done_q.size();
        sel = (v.div == 2);
        slave_byte = v.sbyte;
        rw_v = v.rw; addr_v = v.addr; wdata_v = v.wdata;
        start_v = 1'b1;
        @(negedge CLK);
        start_v = 1'b0;
        rw_v = 1'($urandom); addr_v = 7'($urandom); wdata_v = 8'($urandom);
        for (int i = 0; i < int'(35 * v.div + 20) && done_q.size() == nd; i++) @(negedge CLK);
        repeat (3) @(negedge CLK);
        check("done_pulses", done_q.size() - nd, 1);
        if (done_q.size() > nd && rise_q.size() > nf) begin
            check("latency", done_q[nd] - fall_q[nf], int'(v.exp_lat));
            check("cs_low", rise_q[nf] - fall_q[nf], int'(34 * v.div));
            check("busy_len", busy_q[nd], int'(35 * v.div));
            check("mosi_frame", int'(frame_q[nf]), int'(v.exp_frame));
            check("sclk_rises", nrise_q[nf], 16);
        end
        check("rdata", int'(rdata_s), int'(v.exp_rdata));
    endtask

    vec_t       vecs[$];
    logic [7:0] last_rd[2];

    initial begin
        vec_t       v;
        int         bad;
        int         nf;
        int         nd;
        logic [6:0] a1;
        logic [6:0] a2;
        logic [7:0] d1;
        logic [7:0] sb;

        // Directed vectors first, then random ones with model-derived expectations
        vecs.push_back('{5, 1'b0, 7'h55, 8'h33, 8'hC9, 16'h5533, 175, 8'h00});
        vecs.push_back('{5, 1'b1, 7'h55, 8'hEE, 8'h33, 16'hD500, 175, 8'h33});
        vecs.push_back('{2, 1'b0, 7'h55, 8'h33, 8'h5A, 16'h5533, 70,  8'h00});
        last_rd[0] = 8'h33;
        last_rd[1] = 8'h00;
        for (int i = 0; i < 10; i++) begin
            int k;
            k = int'($urandom_range(0, 1));
            v.div = (k == 1) ? 2 : 5;
            v.rw = 1'($urandom);
            v.addr = 7'($urandom);
            v.wdata = 8'($urandom);
            v.sbyte = 8'($urandom);
            v.exp_frame = 16'(ref_frame(v.rw, v.addr, v.wdata));
            v.exp_lat = 35 * v.div;
            if (v.rw) last_rd[k] = v.sbyte;
            v.exp_rdata = last_rd[k];
            vecs.push_back(v);
        end

        // Reset state and quiet idle
        RESET = 1'b1;
        repeat (2) @(negedge CLK);
        RESET = 1'b0;
        check("rst_cs", int'(cs5), 1);
        check("rst_sclk", int'(sclk5), 0);
        check("rst_mosi", int'(mosi5), 0);
        check("rst_busy", int'(h5.busy), 0);
        check("rst_done", int'(h5.done), 0);
        check("rst_rdata", int'(h5.rdata), 0);
        clear_mon();
        bad = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge CLK);
            if (cs5 !== 1'b1 || sclk5 !== 1'b0 || mosi5 !== 1'b0 || h5.busy !== 1'b0 ||
                h5.done !== 1'b0 || cs2 !== 1'b1 || sclk2 !== 1'b0 || h2.busy !== 1'b0)
                bad++;
        end
        check("idle_50", bad, 0);

        foreach (vecs[i]) do_frame(vecs[i]);

        // Start while busy: second command at bit 6 of a read is dropped
        sel = 1'b0;
        sb = 8'($urandom_range(1, 255));
        a1 = 7'($urandom);
        slave_byte = sb;
        nf = fall_q.size();
        nd = done_q.size();
        rw_v = 1'b1; addr_v = a1; wdata_v = 8'hFF; start_v = 1'b1;
        @(negedge CLK);
        start_v = 1'b0;
        @(negedge CLK);
        for (int i = 0; i < 400 && rise_cnt < 6; i++) @(negedge CLK);
        check("bsy_at_bit6", int'(rise_cnt == 6), 1);
        rw_v = 1'b0; addr_v = 7'h7F; wdata_v = 8'hA5; start_v = 1'b1;
        @(negedge CLK);
        start_v = 1'b0;
        for (int i = 0; i < 300 && done_q.size() == nd; i++) @(negedge CLK);
        repeat (100) @(negedge CLK);
        check("bsy_frames", fall_q.size() - nf, 1);
        check("bsy_dones", done_q.size() - nd, 1);
        if (frame_q.size() > nf)
            check("bsy_frame", int'(frame_q[nf]), ref_frame(1'b1, a1, 8'h00));
        check("bsy_rdata", int'(rdata_s), int'(sb));

        // Back-to-back: start held high across two commands
        a1 = 7'($urandom); d1 = 8'($urandom); a2 = 7'($urandom);
        sb = 8'($urandom);
        slave_byte = sb;
        nf = fall_q.size();
        nd = done_q.size();
        rw_v = 1'b0; addr_v = a1; wdata_v = d1; start_v = 1'b1;
        for (int i = 0; i < 50 && fall_q.size() == nf; i++) @(negedge CLK);
        rw_v = 1'b1; addr_v = a2; wdata_v = 8'($urandom);
        for (int i = 0; i < 400 && fall_q.size() < nf + 2; i++) @(negedge CLK);
        start_v = 1'b0;
        for (int i = 0; i < 400 && done_q.size() < nd + 2; i++) @(negedge CLK);
        repeat (3) @(negedge CLK);
        check("b2b_frames", fall_q.size() - nf, 2);
        check("b2b_dones", done_q.size() - nd, 2);
        if (fall_q.size() >= nf + 2 && done_q.size() >= nd + 2 && rise_q.size() >= nf + 2) begin
            check("b2b_done_gap", done_q[nd + 1] - done_q[nd], 176);
            check("b2b_cs_after_done", fall_q[nf + 1] - done_q[nd], 1);
            check("b2b_cs_high_min", int'(fall_q[nf + 1] - rise_q[nf] >= 6), 1);
            check("b2b_frame1", int'(frame_q[nf]), ref_frame(1'b0, a1, d1));
            check("b2b_frame2", int'(frame_q[nf + 1]), ref_frame(1'b1, a2, 8'h00));
        end
        check("b2b_rdata", int'(rdata_s), int'(sb));

        // Reset mid-transfer at bit 5 of a write
        wdata_v = 8'($urandom); addr_v = 7'($urandom); rw_v = 1'b0; start_v = 1'b1;
        @(negedge CLK);
        start_v = 1'b0;
        @(negedge CLK);
        for (int i = 0; i < 400 && rise_cnt < 5; i++) @(negedge CLK);
        check("mid_at_bit5", int'(rise_cnt == 5), 1);
        RESET = 1'b1;
        @(negedge CLK);
        check("mid_cs", int'(cs5), 1);
        check("mid_sclk", int'(sclk5), 0);
        check("mid_mosi", int'(mosi5), 0);
        check("mid_busy", int'(h5.busy), 0);
        check("mid_done", int'(h5.done), 0);
        check("mid_rdata", int'(h5.rdata), 0);
        RESET = 1'b0;
        clear_mon();
        repeat (200) @(negedge CLK);
        check("mid_no_done", done_q.size(), 0);
        check("mid_no_frame", fall_q.size(), 0);
        check("stray_sclk", stray, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

endmodule
